// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size codes, FSM states and
// the alignment rule used when deciding whether a request may touch memory.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // A request errors if its size is reserved or its offset is not a multiple of the size.
  function automatic logic access_err(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: access_err = 1'b0;
      SZ_HALF: access_err = off[0];
      SZ_WORD: access_err = |off;
      default: access_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian byte-lane steering: builds BE/WD for stores and extracts and
// extends load data from the memory read word. Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rd,
  output logic [3:0]  be,
  output logic [31:0] wd,
  output logic [31:0] rdata,
  output logic        err
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Offset 0 is the most significant byte, so lane k sits at bit 8*(3-k).
  assign byte_lane = rd[{~off, 3'b000} +: 8];
  assign half_lane = off[1] ? rd[15:0] : rd[31:16];
  assign err       = access_err(size, off);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned, which would infer a latch.
    be    = 4'b0000;
    wd    = '0;
    rdata = '0;
    case (size)
      SZ_BYTE: begin
        be    = 4'b1000 >> off;
        wd    = {4{wdata[7:0]}};
        rdata = is_unsigned ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      SZ_HALF: begin
        be    = off[1] ? 4'b0011 : 4'b1100;
        wd    = {2{wdata[15:0]}};
        rdata = is_unsigned ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      end
      SZ_WORD: begin
        be    = 4'b1111;
        wd    = wdata;
        rdata = rd;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a byte-enabled data memory: one request at a time,
// IDLE -> ACCESS -> RESP, with misaligned/reserved requests answered directly.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          mem_WE,
  output logic [3:0]    mem_BE,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WD,
  input  logic [DW-1:0] mem_RD
);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  size_e         size_q, size_d;
  logic          uns_q, uns_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;

  logic          in_idle, in_access;
  size_e         al_size;
  logic [1:0]    al_off;
  logic [3:0]    al_be;
  logic [DW-1:0] al_wd, al_rdata;
  logic          al_err;

  assign in_idle   = (state_q == IDLE);
  assign in_access = (state_q == ACCESS);

  // While idle the aligner judges the incoming request; afterwards it decodes the registered one.
  assign al_size = in_idle ? size_e'(req_size) : size_q;
  assign al_off  = in_idle ? req_addr[1:0] : addr_q[1:0];

  lsu_lane_align u_align (
    .size        (al_size),
    .off         (al_off),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rd          (mem_RD),
    .be          (al_be),
    .wd          (al_wd),
    .rdata       (al_rdata),
    .err         (al_err)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = size_e'(req_size);
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (al_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = we_q ? '0 : al_rdata;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = in_idle;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  // Reset forces IDLE asynchronously, so the write strobe drops without waiting for a clock.
  assign mem_A  = {addr_q[AW-1:2], 2'b00};
  assign mem_WE = in_access & we_q;
  assign mem_BE = in_access ? al_be : 4'b0000;
  assign mem_WD = in_access ? al_wd : '0;

endmodule
